// File: rtl/ysyx_23060020_mem_arbiter.sv
// Arbitrates the single combinational pmem port between IFU (read-only) and LSU (read/write).
// One outstanding transaction; programmable access latency; round-robin on simultaneous requests.
module ysyx_23060020_mem_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic        owner_lsu_r;
  logic        last_lsu_r;
  logic        wen_r;
  logic [31:0] rdata_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        grant_ifu_s;
  logic        grant_lsu_s;
  logic        access_s;
  logic        resp_hs_s;

  // Grant selection: on a tie, the side that did not win last time goes first.
  always_comb begin
    grant_ifu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_lsu_s = !last_lsu_r;
        grant_ifu_s = last_lsu_r;
      end else begin
        grant_lsu_s = lsu_req_valid;
        grant_ifu_s = ifu_req_valid;
      end
    end else begin
      grant_ifu_s = 1'b0;
      grant_lsu_s = 1'b0;
    end
  end

  // Outputs are decoded from registered state; rst masks them so a reset never strobes memory.
  always_comb begin
    access_s       = (state_r == WAIT) && (cnt_r == 4'd0) && !rst;
    resp_hs_s      = owner_lsu_r ? lsu_resp_ready : ifu_resp_ready;
    ifu_req_ready  = grant_ifu_s;
    lsu_req_ready  = grant_lsu_s;
    mem_ren        = access_s;
    mem_wen        = access_s && wen_r;
    mem_addr       = mem_addr_r;
    mem_wdata      = mem_wdata_r;
    ifu_resp_valid = (state_r == RESP) && !owner_lsu_r && !rst;
    lsu_resp_valid = (state_r == RESP) && owner_lsu_r && !rst;
    ifu_rdata      = ifu_resp_valid ? rdata_r : 32'd0;
    lsu_rdata      = lsu_resp_valid ? rdata_r : 32'd0;
  end

  // Next-state and latency counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (grant_ifu_s || grant_lsu_s) begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = LAT_M1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (resp_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      owner_lsu_r <= 1'b0;
      last_lsu_r  <= 1'b0;
      wen_r       <= 1'b0;
      rdata_r     <= 32'd0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (grant_lsu_s) begin
        owner_lsu_r <= 1'b1;
        last_lsu_r  <= 1'b1;
        wen_r       <= lsu_wen;
        mem_addr_r  <= lsu_addr;
        mem_wdata_r <= lsu_wdata;
      end else if (grant_ifu_s) begin
        owner_lsu_r <= 1'b0;
        last_lsu_r  <= 1'b0;
        wen_r       <= 1'b0;
        mem_addr_r  <= ifu_addr;
        mem_wdata_r <= 32'd0;
      end
      // A store's pre-write word is not returned to the LSU.
      if (access_s) begin
        rdata_r <= wen_r ? 32'd0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060020_mem_arbiter.sv
// Directed and random self-checking bench for ysyx_23060020_mem_arbiter (LAT=1 and LAT=4 instances).
module tb_ysyx_23060020_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic mem_init;

  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        ifu4_req_valid, ifu4_req_ready, ifu4_resp_valid, ifu4_resp_ready;
  logic [31:0] ifu4_addr, ifu4_rdata;
  logic        lsu4_req_ready, lsu4_resp_valid;
  logic [31:0] lsu4_rdata;
  logic        mem4_ren, mem4_wen;
  logic [31:0] mem4_addr, mem4_wdata, mem4_rdata;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int acc_cnt = 0;
  int wen_cnt = 0;
  int checks = 0;
  int failures = 0;
  logic last_lsu;
  int ifu_wait, lsu_wait;

  ysyx_23060020_mem_arbiter #(.LAT(1)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  ysyx_23060020_mem_arbiter #(.LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu4_req_valid), .ifu_req_ready(ifu4_req_ready), .ifu_addr(ifu4_addr),
    .ifu_resp_valid(ifu4_resp_valid), .ifu_resp_ready(ifu4_resp_ready), .ifu_rdata(ifu4_rdata),
    .lsu_req_valid(1'b0), .lsu_req_ready(lsu4_req_ready), .lsu_addr(32'd0),
    .lsu_wen(1'b0), .lsu_wdata(32'd0),
    .lsu_resp_valid(lsu4_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(lsu4_rdata),
    .mem_ren(mem4_ren), .mem_wen(mem4_wen), .mem_addr(mem4_addr), .mem_wdata(mem4_wdata),
    .mem_rdata(mem4_rdata)
  );

  function automatic logic [31:0] pat(int i);
    return (i == 0) ? 32'h0000_0413 : (32'hC0DE_0000 | 32'(i));
  endfunction

  assign mem_rdata  = mem[mem_addr[11:2]];
  assign mem4_rdata = mem4_addr ^ 32'h1234_5678;

  // Memory model for the LAT=1 instance, plus access counters.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (mem_wen) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
    if (mem_ren) acc_cnt <= acc_cnt + 1;
    if (mem_wen) wen_cnt <= wen_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One LAT=1 transaction from the accept cycle through the response handshake.
  task automatic run_txn();
    logic win_lsu, st;
    logic [31:0] a, wd, exp;
    int acc0, wen0;
    #1;
    win_lsu = (ifu_req_valid && lsu_req_valid) ? !last_lsu : lsu_req_valid;
    check("ifu_req_ready", 32'(ifu_req_ready), 32'(!win_lsu));
    check("lsu_req_ready", 32'(lsu_req_ready), 32'(win_lsu));
    check("ren_at_accept", 32'(mem_ren), 32'd0);
    if (win_lsu) begin
      a = lsu_addr; st = lsu_wen; wd = lsu_wdata;
      check("lsu_starve", 32'(lsu_wait > 1), 32'd0);
      lsu_wait = 0;
      if (ifu_req_valid) ifu_wait++;
    end else begin
      a = ifu_addr; st = 1'b0; wd = 32'd0;
      check("ifu_starve", 32'(ifu_wait > 1), 32'd0);
      ifu_wait = 0;
      if (lsu_req_valid) lsu_wait++;
    end
    exp = st ? 32'd0 : ref_mem[a[11:2]];
    if (st) ref_mem[a[11:2]] = wd;
    last_lsu = win_lsu;
    acc0 = acc_cnt;
    wen0 = wen_cnt;
    tick();
    if (win_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    #1;
    check("ren_access", 32'(mem_ren), 32'd1);
    check("wen_access", 32'(mem_wen), 32'(st));
    check("mem_addr", mem_addr, a);
    if (st) check("mem_wdata", mem_wdata, wd);
    check("ready_in_wait", 32'(ifu_req_ready | lsu_req_ready), 32'd0);
    tick();
    #1;
    check("ifu_resp_valid", 32'(ifu_resp_valid), 32'(!win_lsu));
    check("lsu_resp_valid", 32'(lsu_resp_valid), 32'(win_lsu));
    check("ifu_rdata", ifu_rdata, win_lsu ? 32'd0 : exp);
    check("lsu_rdata", lsu_rdata, win_lsu ? exp : 32'd0);
    check("ren_in_resp", 32'(mem_ren), 32'd0);
    check("ready_in_resp", 32'(ifu_req_ready | lsu_req_ready), 32'd0);
    check("one_access", 32'(acc_cnt - acc0), 32'd1);
    check("store_wen_count", 32'(wen_cnt - wen0), 32'(st));
    tick();
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1; last_lsu = 1'b0; ifu_wait = 0; lsu_wait = 0;
    ifu_req_valid = 1'b0; ifu_addr = 32'd0; ifu_resp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0; lsu_wdata = 32'd0; lsu_resp_ready = 1'b1;
    ifu4_req_valid = 1'b0; ifu4_addr = 32'd0; ifu4_resp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    tick(); tick();
    mem_init = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu4_req_valid = 1'b1;
    #1;
    check("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
    check("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
    check("rst_ifu4_ready", 32'(ifu4_req_ready), 32'd0);
    check("rst_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
    check("rst_ren", 32'(mem_ren | mem_wen), 32'd0);
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; ifu4_req_valid = 1'b0; rst = 1'b0;
    #1;
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
    tick();

    // Single IFU fetch, LAT=1.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    run_txn();

    // Three back-to-back ties: LSU, IFU, LSU.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020; lsu_wen = 1'b0;
    #1 check("tie1_lsu", 32'(lsu_req_ready), 32'd1);
    run_txn();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0024;
    #1 check("tie2_ifu", 32'(ifu_req_ready), 32'd1);
    run_txn();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0014;
    #1 check("tie3_lsu", 32'(lsu_req_ready), 32'd1);
    run_txn();
    run_txn();

    // Store then load to the same address.
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF;
    run_txn();
    check("store_in_mem", mem[64], 32'hDEAD_BEEF);
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_wdata = 32'd0;
    #1 check("load_accept", 32'(lsu_req_ready), 32'd1);
    tick(); lsu_req_valid = 1'b0;
    tick(); #1 check("load_data", lsu_rdata, 32'hDEAD_BEEF);
    tick();

    // LAT=4 with a stalled response and a second request waiting.
    ifu4_req_valid = 1'b1; ifu4_addr = 32'h8000_0040; ifu4_resp_ready = 1'b0;
    #1 check("t4_accept", 32'(ifu4_req_ready), 32'd1);
    tick();
    ifu4_addr = 32'h8000_0080;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("t4_wait_resp", 32'(ifu4_resp_valid), 32'd0);
      check("t4_wait_ready", 32'(ifu4_req_ready), 32'd0);
      check("t4_ren", 32'(mem4_ren), 32'(k == 4));
      tick();
    end
    for (int k = 5; k <= 8; k++) begin
      if (k == 8) ifu4_resp_ready = 1'b1;
      #1;
      check("t4_resp_valid", 32'(ifu4_resp_valid), 32'd1);
      check("t4_rdata", ifu4_rdata, 32'h9234_5638);
      check("t4_hold_ready", 32'(ifu4_req_ready), 32'd0);
      tick();
    end
    #1 check("t4_next_accept", 32'(ifu4_req_ready), 32'd1);
    tick();
    ifu4_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #1 check("t4_second_rdata", ifu4_rdata, 32'h9234_56F8);
    tick();
    #1 check("t4_idle_resp", 32'(ifu4_resp_valid), 32'd0);
    tick();

    // Reset during a store's access cycle.
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b1; lsu_wdata = 32'h1111_2222;
    #1 check("t5_accept", 32'(lsu_req_ready), 32'd1);
    tick();
    lsu_req_valid = 1'b0; rst = 1'b1;
    #1;
    check("t5_wen_masked", 32'(mem_wen), 32'd0);
    check("t5_ren_masked", 32'(mem_ren), 32'd0);
    tick();
    rst = 1'b0; last_lsu = 1'b0; ifu_wait = 0; lsu_wait = 0;
    #1;
    check("t5_outs", mem_addr | mem_wdata | ifu_rdata | lsu_rdata, 32'd0);
    check("t5_flags", 32'({ifu_resp_valid, lsu_resp_valid, mem_ren, mem_wen}), 32'd0);
    tick(); tick();
    check("t5_mem_kept", mem[128], pat(128));
    check("t5_no_access", 32'(mem_ren | mem_wen), 32'd0);

    // Random traffic against the reference memory.
    for (int n = 0; n < 1000; n++) begin
      if (!ifu_req_valid && ($urandom_range(0, 1) == 1)) begin
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 32'd4;
      end
      if (!lsu_req_valid && (($urandom_range(0, 1) == 1) || !ifu_req_valid)) begin
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 32'd4;
        lsu_wen = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom;
      end
      run_txn();
    end
    while (ifu_req_valid || lsu_req_valid) run_txn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
